// File: rtl/contador_0_13_pkg.sv
// Shared constants for the contador_0_13 counter slice.
// Holds the default count range and the active-high seven-segment
// patterns, packed as {g,f,e,d,c,b,a}.
package contador_0_13_pkg;

  localparam int unsigned CNT_WIDTH_DEFAULT = 4;
  localparam int unsigned CNT_MAX_DEFAULT   = 13;
  localparam int unsigned SEG_WIDTH         = 7;

  typedef logic [SEG_WIDTH-1:0] seg_t;

  // Segment patterns {g,f,e,d,c,b,a}, 1 = segment lit
  localparam seg_t SEG_0   = 7'b011_1111;
  localparam seg_t SEG_1   = 7'b000_0110;
  localparam seg_t SEG_2   = 7'b101_1011;
  localparam seg_t SEG_3   = 7'b100_1111;
  localparam seg_t SEG_4   = 7'b110_0110;
  localparam seg_t SEG_5   = 7'b110_1101;
  localparam seg_t SEG_6   = 7'b111_1101;
  localparam seg_t SEG_7   = 7'b000_0111;
  localparam seg_t SEG_8   = 7'b111_1111;
  localparam seg_t SEG_9   = 7'b110_1111;
  localparam seg_t SEG_A   = 7'b111_0111;
  localparam seg_t SEG_B   = 7'b111_1100;
  localparam seg_t SEG_C   = 7'b011_1001;
  localparam seg_t SEG_D   = 7'b101_1110;
  localparam seg_t SEG_OFF = 7'b000_0000;

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational hex-digit to seven-segment decoder for digits 0-D.
// Ports:
//   code : WIDTH-bit value to display
//   seg  : active-high pattern {g,f,e,d,c,b,a}; blank for codes above D
module hex7seg_dec
  import contador_0_13_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] code,
  output seg_t             seg
);

  // Decode on a zero-extended copy so any WIDTH maps the same digits
  always_comb begin
    seg = SEG_OFF;
    case (32'(code))
      32'd0:   seg = SEG_0;
      32'd1:   seg = SEG_1;
      32'd2:   seg = SEG_2;
      32'd3:   seg = SEG_3;
      32'd4:   seg = SEG_4;
      32'd5:   seg = SEG_5;
      32'd6:   seg = SEG_6;
      32'd7:   seg = SEG_7;
      32'd8:   seg = SEG_8;
      32'd9:   seg = SEG_9;
      32'd10:  seg = SEG_A;
      32'd11:  seg = SEG_B;
      32'd12:  seg = SEG_C;
      32'd13:  seg = SEG_D;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/contador_0_13.sv
// Modulo-(MAX+1) up/down counter with saturating parallel load,
// terminal-count flag, wrap pulse and seven-segment display output.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset (q=0, wrap=0)
//   en    : count enable, one step per clock
//   up_dn : 1 = count up, 0 = count down
//   load  : load d (saturated to MAX) on the next edge, beats en
//   d     : load value
//   q     : registered count, always within 0..MAX
//   tc    : combinational terminal count for the current direction
//   wrap  : registered one-cycle pulse after a MAX<->0 roll-over
//   seg   : seven-segment pattern of q
module contador_0_13
  import contador_0_13_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_WIDTH_DEFAULT,
  parameter int unsigned MAX   = CNT_MAX_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output seg_t             seg
);

  localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ZERO_Q = WIDTH'(0);
  localparam logic [WIDTH-1:0] ONE_Q  = WIDTH'(1);

  logic [WIDTH-1:0] d_sat;

  // Clamp load values above the terminal count
  assign d_sat = (d > MAX_Q) ? MAX_Q : d;

  // Counter core: reset > load > enabled step > hold
  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= ZERO_Q;
      wrap <= 1'b0;
    end else if (load) begin
      q    <= d_sat;
      wrap <= 1'b0;
    end else if (en) begin
      if (up_dn) begin
        // >= keeps q in range even from an unexpected code
        if (q >= MAX_Q) begin
          q    <= ZERO_Q;
          wrap <= 1'b1;
        end else begin
          q    <= q + ONE_Q;
          wrap <= 1'b0;
        end
      end else begin
        if (q == ZERO_Q || q > MAX_Q) begin
          q    <= MAX_Q;
          wrap <= (q == ZERO_Q);
        end else begin
          q    <= q - ONE_Q;
          wrap <= 1'b0;
        end
      end
    end else begin
      wrap <= 1'b0;
    end
  end

  // Terminal count follows the direction currently requested
  assign tc = up_dn ? (q == MAX_Q) : (q == ZERO_Q);

  hex7seg_dec #(
    .WIDTH (WIDTH)
  ) u_hex7seg_dec (
    .code (q),
    .seg  (seg)
  );

endmodule

// File: tb/tb_contador_0_13.sv
module tb_contador_0_13;

  localparam int unsigned W = 4;
  localparam int unsigned M = 13;

  typedef struct {
    int unsigned q;
    logic        wrap;
    logic        tc;
    logic [6:0]  seg;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         en;
  logic         up_dn;
  logic         load;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic         tc;
  logic         wrap;
  logic [6:0]   seg;

  exp_t        sb[$];
  exp_t        e;
  int unsigned mq;
  logic        mw;
  int          total;
  int          bad;

  contador_0_13 #(
    .WIDTH (W),
    .MAX   (M)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .up_dn (up_dn),
    .load  (load),
    .d     (d),
    .q     (q),
    .tc    (tc),
    .wrap  (wrap),
    .seg   (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] seg_ref(input int unsigned v);
    case (v)
      0:  return 7'h3F;
      1:  return 7'h06;
      2:  return 7'h5B;
      3:  return 7'h4F;
      4:  return 7'h66;
      5:  return 7'h6D;
      6:  return 7'h7D;
      7:  return 7'h07;
      8:  return 7'h7F;
      9:  return 7'h6F;
      10: return 7'h77;
      11: return 7'h7C;
      12: return 7'h39;
      13: return 7'h5E;
      default: return 7'h00;
    endcase
  endfunction

  // Drive one cycle, advance the reference model, push expectation,
  // then step to just after the rising edge.
  task automatic drive(input logic r, input logic n, input logic u,
                       input logic l, input int unsigned dv);
    exp_t x;
    rst = r; en = n; up_dn = u; load = l; d = W'(dv);
    if (r) begin
      mq = 0; mw = 1'b0;
    end else if (l) begin
      mq = (dv > M) ? M : dv; mw = 1'b0;
    end else if (n) begin
      if (u) begin
        mw = (mq == M);
        mq = (mq + 1) % (M + 1);
      end else begin
        mw = (mq == 0);
        mq = (mq + M) % (M + 1);
      end
    end else begin
      mw = 1'b0;
    end
    x.q = mq; x.wrap = mw;
    x.tc = u ? (mq == M) : (mq == 0);
    x.seg = seg_ref(mq);
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 9);
    e = sb.pop_front();
    total++; if (q !== W'(e.q)) begin bad++; $display("FAIL reset q got=%0d exp=%0d", q, e.q); end
    total++; if (wrap !== e.wrap) begin bad++; $display("FAIL reset wrap got=%0b exp=%0b", wrap, e.wrap); end
    total++; if (tc !== e.tc) begin bad++; $display("FAIL reset tc_down got=%0b exp=%0b", tc, e.tc); end
    total++; if (seg !== 7'b0111111) begin bad++; $display("FAIL reset seg got=%b exp=0111111", seg); end
    up_dn = 1'b1;
    #1;
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL reset tc_up got=%0b exp=0", tc); end
  endtask

  task automatic test_count_up();
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 0);
      e = sb.pop_front();
      total++; if (q !== W'(e.q)) begin bad++; $display("FAIL count_up[%0d] q got=%0d exp=%0d", i, q, e.q); end
      total++; if (wrap !== e.wrap) begin bad++; $display("FAIL count_up[%0d] wrap got=%0b exp=%0b", i, wrap, e.wrap); end
      total++; if (tc !== e.tc) begin bad++; $display("FAIL count_up[%0d] tc got=%0b exp=%0b", i, tc, e.tc); end
      total++; if (seg !== e.seg) begin bad++; $display("FAIL count_up[%0d] seg got=%b exp=%b", i, seg, e.seg); end
    end
  endtask

  task automatic test_count_down();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 0);
    void'(sb.pop_front());
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 0);
      e = sb.pop_front();
      total++; if (q !== W'(e.q)) begin bad++; $display("FAIL count_down[%0d] q got=%0d exp=%0d", i, q, e.q); end
      total++; if (wrap !== e.wrap) begin bad++; $display("FAIL count_down[%0d] wrap got=%0b exp=%0b", i, wrap, e.wrap); end
      total++; if (tc !== e.tc) begin bad++; $display("FAIL count_down[%0d] tc got=%0b exp=%0b", i, tc, e.tc); end
      total++; if (seg !== e.seg) begin bad++; $display("FAIL count_down[%0d] seg got=%b exp=%b", i, seg, e.seg); end
    end
  endtask

  task automatic test_hold();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 5);
    void'(sb.pop_front());
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, i[0], 1'b0, 0);
      e = sb.pop_front();
      total++; if (q !== W'(e.q)) begin bad++; $display("FAIL hold[%0d] q got=%0d exp=%0d", i, q, e.q); end
      total++; if (wrap !== e.wrap) begin bad++; $display("FAIL hold[%0d] wrap got=%0b exp=%0b", i, wrap, e.wrap); end
    end
  endtask

  task automatic test_load();
    int unsigned vals[6] = '{9, 15, 0, 13, 14, 3};
    logic        dirs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, dirs[i], 1'b1, vals[i]);
      e = sb.pop_front();
      total++; if (q !== W'(e.q)) begin bad++; $display("FAIL load[%0d] q got=%0d exp=%0d", i, q, e.q); end
      total++; if (wrap !== e.wrap) begin bad++; $display("FAIL load[%0d] wrap got=%0b exp=%0b", i, wrap, e.wrap); end
      total++; if (seg !== e.seg) begin bad++; $display("FAIL load[%0d] seg got=%b exp=%b", i, seg, e.seg); end
    end
  endtask

  task automatic test_direction_change();
    logic dirs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    drive(1'b0, 1'b0, 1'b1, 1'b1, 12);
    void'(sb.pop_front());
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, dirs[i], 1'b0, 0);
      e = sb.pop_front();
      total++; if (q !== W'(e.q)) begin bad++; $display("FAIL dir_change[%0d] q got=%0d exp=%0d", i, q, e.q); end
      total++; if (wrap !== e.wrap) begin bad++; $display("FAIL dir_change[%0d] wrap got=%0b exp=%0b", i, wrap, e.wrap); end
      total++; if (tc !== e.tc) begin bad++; $display("FAIL dir_change[%0d] tc got=%0b exp=%0b", i, tc, e.tc); end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 6);
    void'(sb.pop_front());
    drive(1'b0, 1'b1, 1'b1, 1'b0, 0);
    e = sb.pop_front();
    total++; if (q !== W'(e.q)) begin bad++; $display("FAIL reset_mid pre q got=%0d exp=%0d", q, e.q); end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 11);
    e = sb.pop_front();
    total++; if (q !== W'(e.q)) begin bad++; $display("FAIL reset_mid q got=%0d exp=%0d", q, e.q); end
    total++; if (seg !== 7'b0111111) begin bad++; $display("FAIL reset_mid seg got=%b exp=0111111", seg); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL reset_mid wrap got=%0b exp=0", wrap); end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 0);
    e = sb.pop_front();
    total++; if (q !== W'(e.q)) begin bad++; $display("FAIL reset_mid restart q got=%0d exp=%0d", q, e.q); end
  endtask

  task automatic test_random();
    logic r, n, u, l;
    int unsigned dv;
    for (int i = 0; i < 60; i++) begin
      r  = ($urandom_range(0, 15) == 0);
      l  = ($urandom_range(0, 5) == 0);
      n  = ($urandom_range(0, 3) != 0);
      u  = 1'($urandom_range(0, 1));
      dv = $urandom_range(0, 15);
      drive(r, n, u, l, dv);
      e = sb.pop_front();
      total++; if (q !== W'(e.q) || q > W'(M)) begin bad++; $display("FAIL random[%0d] q got=%0d exp=%0d", i, q, e.q); end
      total++; if (wrap !== e.wrap) begin bad++; $display("FAIL random[%0d] wrap got=%0b exp=%0b", i, wrap, e.wrap); end
      total++; if (tc !== e.tc) begin bad++; $display("FAIL random[%0d] tc got=%0b exp=%0b", i, tc, e.tc); end
      total++; if (seg !== e.seg) begin bad++; $display("FAIL random[%0d] seg got=%b exp=%b", i, seg, e.seg); end
    end
  endtask

  initial begin
    total = 0; bad = 0; mq = 0; mw = 1'b0;
    rst = 1'b0; en = 1'b0; up_dn = 1'b0; load = 1'b0; d = '0;
    test_reset();
    test_count_up();
    test_count_down();
    test_hold();
    test_load();
    test_direction_change();
    test_reset_mid();
    test_random();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL scoreboard leftover got=%0d exp=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
